// File: rtl/vsfx_pkg.sv
// vsfx_pkg: shared VSFX opcodes, lane-size encoding and default widths
package vsfx_pkg;
    localparam int VSFX_DATA_W = 32;
    localparam int VSFX_TAG_W = 5;
    localparam logic [2:0] VSFX_OP_ADDUBM = 3'b000;
    localparam logic [2:0] VSFX_OP_ADDUHM = 3'b001;
    localparam logic [2:0] VSFX_OP_ADDUWM = 3'b010;
    localparam logic [2:0] VSFX_OP_SUBUBM = 3'b100;
    localparam logic [2:0] VSFX_OP_SUBUHM = 3'b101;
    localparam logic [2:0] VSFX_OP_SUBUWM = 3'b110;
    typedef enum logic [1:0] {
        LANE_B   = 2'b00,
        LANE_H   = 2'b01,
        LANE_W   = 2'b10,
        LANE_ILL = 2'b11
    } vsfx_lane_e;
endpackage

// File: rtl/vsfx_modarith_pipe_if.sv
// vsfx_modarith_pipe_if: issue and writeback handshakes of the modulo add/sub pipe
interface vsfx_modarith_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_vra;
    logic [DATA_W-1:0] in_vrb;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_vrt;
    logic [TAG_W-1:0]  out_tag;
    logic              out_ill;
    modport master (
        output in_valid, in_op, in_vra, in_vrb, in_tag, out_ready,
        input  in_ready, out_valid, out_vrt, out_tag, out_ill
    );
    modport slave (
        input  in_valid, in_op, in_vra, in_vrb, in_tag, out_ready,
        output in_ready, out_valid, out_vrt, out_tag, out_ill
    );
endinterface

// File: rtl/vsfx_modarith_lanes.sv
// vsfx_modarith_lanes: lane-wise modulo add/sub using one 36-bit adder per 32-bit slice
module vsfx_modarith_lanes
    import vsfx_pkg::*;
#(
    parameter int DATA_W = VSFX_DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] r_o,
    output logic              ill_o
);
    vsfx_lane_e lane;
    logic       sub;
    logic [2:0] bnd;
    logic [2:0] sep;
    assign lane  = vsfx_lane_e'(op_i[1:0]);
    assign sub   = op_i[2];
    assign ill_o = lane == LANE_ILL;
    // A separator bit sitting on a lane boundary blocks carry/borrow (0/0 add, 1/0 sub);
    // inside a lane it passes carry/borrow through (1/0 add, 0/0 sub).
    assign bnd = {lane == LANE_B, lane == LANE_B || lane == LANE_H, lane == LANE_B};
    assign sep = ~(bnd ^ {3{sub}});
    for (genvar g = 0; g < DATA_W / 32; g++) begin : g_slice
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] ga;
        logic [35:0] gb;
        logic [35:0] gr;
        logic [31:0] r;
        logic [3:0]  sep_unused;
        assign a  = a_i[32*g +: 32];
        assign b  = b_i[32*g +: 32];
        assign ga = {1'b0, a[31:24], sep[2], a[23:16], sep[1], a[15:8], sep[0], a[7:0]};
        assign gb = {1'b0, b[31:24], 1'b0, b[23:16], 1'b0, b[15:8], 1'b0, b[7:0]};
        assign gr = sub ? ga - gb : ga + gb;
        assign {sep_unused[3], r[31:24], sep_unused[2], r[23:16], sep_unused[1], r[15:8],
                sep_unused[0], r[7:0]} = gr;
        assign r_o[32*g +: 32] = ill_o ? '0 : r;
    end
endmodule

// File: rtl/vsfx_modarith_pipe.sv
// vsfx_modarith_pipe: two-stage VSFX modulo add/sub unit with valid/ready on both sides
module vsfx_modarith_pipe
    import vsfx_pkg::*;
#(
    parameter int DATA_W = VSFX_DATA_W,
    parameter int TAG_W  = VSFX_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    vsfx_modarith_pipe_if.slave pipe_io
);
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s1_adv, s2_adv, s1_load, s2_load;
    logic [2:0]        s1_op_q;
    logic [DATA_W-1:0] s1_vra_q, s1_vrb_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic [DATA_W-1:0] s2_vrt_q, lane_r;
    logic [TAG_W-1:0]  s2_tag_q;
    logic              s2_ill_q, lane_ill;
    vsfx_modarith_lanes #(.DATA_W(DATA_W)) u_lanes (
        .op_i (s1_op_q),
        .a_i  (s1_vra_q),
        .b_i  (s1_vrb_q),
        .r_o  (lane_r),
        .ill_o(lane_ill)
    );
    // A stage advances when empty or when its consumer takes its content this cycle.
    always_comb begin
        s2_adv     = !s2_valid_q || pipe_io.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_load    = s1_adv && pipe_io.in_valid;
        s2_load    = s2_adv && s1_valid_q;
        s1_valid_d = s1_adv ? pipe_io.in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end
    // Stage valid flags and data; data only moves with a valid op so bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_vra_q   <= '0;
            s1_vrb_q   <= '0;
            s1_tag_q   <= '0;
            s2_vrt_q   <= '0;
            s2_tag_q   <= '0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_op_q  <= pipe_io.in_op;
                s1_vra_q <= pipe_io.in_vra;
                s1_vrb_q <= pipe_io.in_vrb;
                s1_tag_q <= pipe_io.in_tag;
            end
            if (s2_load) begin
                s2_vrt_q <= lane_r;
                s2_tag_q <= s1_tag_q;
                s2_ill_q <= lane_ill;
            end
        end
    end
    assign pipe_io.in_ready  = s1_adv;
    assign pipe_io.out_valid = s2_valid_q;
    assign pipe_io.out_vrt   = s2_vrt_q;
    assign pipe_io.out_tag   = s2_tag_q;
    assign pipe_io.out_ill   = s2_ill_q;
endmodule
